// File: rtl/load_unit.sv
// Load unit for the MEM stage: one lw/lh/lhu/lb/lbu in flight over a req/gnt/rvalid word port,
// with lane select, sign/zero extension and a valid/ready response held until taken.
module load_unit #(
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_option,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, RESP} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_option;
  logic [31:0]       r_data;
  logic              r_err;
  logic              w_accept;
  logic              w_reqErr;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_loadData;
  logic              w_unusedAddr;

  assign w_unusedAddr = ^req_addr[31:ADDR_W];

  assign req_ready = (r_state == IDLE) & reset_n;
  assign w_accept  = req_valid & req_ready;
  assign mem_req   = (r_state == REQ);
  assign mem_addr  = r_addr[ADDR_W-1:2];
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;

  // Errors are judged on the live request so the unit can skip memory entirely.
  always_comb begin
    w_reqErr = 1'b0;
    case (req_option[1:0])
      2'b00:   w_reqErr = (req_addr[1:0] != 2'b00);
      2'b01:   w_reqErr = 1'b0;
      2'b10:   w_reqErr = req_addr[0];
      default: w_reqErr = 1'b1;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = w_reqErr ? RESP : REQ;
      REQ:     if (mem_gnt) w_nextState = DATA;
      DATA:    if (mem_rvalid) w_nextState = RESP;
      RESP:    if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_byte     = mem_rdata[7:0];
    w_half     = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_loadData = mem_rdata;
    case (r_addr[1:0])
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    case (r_option[1:0])
      2'b01:   w_loadData = r_option[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b10:   w_loadData = r_option[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_loadData = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_option <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_addr   <= req_addr[ADDR_W-1:0];
        r_option <= req_option;
        if (w_reqErr) begin
          r_data <= '0;
          r_err  <= 1'b1;
        end
      end
      if ((r_state == DATA) && mem_rvalid) begin
        r_data <= w_loadData;
        r_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: a memory responder with controllable gnt/rvalid timing and a
// queue of expected responses pushed at request time and popped when the response appears.
module tb_load_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_option;
  logic        mem_req;
  logic        mem_gnt;
  logic [10:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int          nChecks = 0;
  int          nFail   = 0;
  logic [32:0] sb[$];
  logic [31:0] memModel[0:2047];

  load_unit #(.ADDR_W(13)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_option(req_option),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full load: request, memory handshake with programmable waits, held response, pop and compare.
  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] opt,
                               input int gntDly, input int rvDly, input int holdCycles,
                               input bit strayRv, input logic expErr, input logic [31:0] expData);
    logic [32:0] exp;
    logic [31:0] heldData;
    logic [10:0] expIdx;
    expIdx = addr[12:2];
    @(posedge clock); #1;
    checkOutput("req_ready_idle", {31'h0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_option = opt;
    sb.push_back({expErr, expData});
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (expErr) begin
      checkOutput("err_rsp_valid", {31'h0, rsp_valid}, 32'd1);
      checkOutput("err_mem_req", {31'h0, mem_req}, 32'd0);
    end else begin
      for (int i = 0; i <= gntDly; i++) begin
        checkOutput("mem_req_high", {31'h0, mem_req}, 32'd1);
        checkOutput("mem_addr", {21'h0, mem_addr}, {21'h0, expIdx});
        checkOutput("rsp_valid_req", {31'h0, rsp_valid}, 32'd0);
        mem_gnt    = (i == gntDly);
        mem_rvalid = strayRv && (i == 0) && (gntDly > 0);
        mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clock); #1;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      for (int i = 0; i <= rvDly; i++) begin
        checkOutput("mem_req_low", {31'h0, mem_req}, 32'd0);
        checkOutput("rsp_valid_data", {31'h0, rsp_valid}, 32'd0);
        if (i == rvDly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memModel[expIdx];
        end
        @(posedge clock); #1;
      end
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      checkOutput("rsp_valid", {31'h0, rsp_valid}, 32'd1);
    end
    heldData = rsp_data;
    for (int i = 0; i < holdCycles; i++) begin
      req_valid = 1'b1;
      @(posedge clock); #1;
      checkOutput("hold_rsp_valid", {31'h0, rsp_valid}, 32'd1);
      checkOutput("hold_rsp_data", rsp_data, heldData);
      checkOutput("hold_req_ready", {31'h0, req_ready}, 32'd0);
      checkOutput("hold_mem_req", {31'h0, mem_req}, 32'd0);
    end
    req_valid = 1'b0;
    checkOutput("sb_count", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      checkOutput("rsp_data", rsp_data, exp[31:0]);
      checkOutput("rsp_err", {31'h0, rsp_err}, {31'h0, exp[32]});
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_done", {31'h0, rsp_valid}, 32'd0);
    checkOutput("req_ready_done", {31'h0, req_ready}, 32'd1);
    checkOutput("mem_req_done", {31'h0, mem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) memModel[i] = 32'h5A5A_0000 ^ i;
    memModel[4]    = 32'h8091_A2B3;
    memModel[2047] = 32'h7F00_FF01;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_option = 3'b000;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    rsp_ready  = 1'b0;
    #2;
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'd0);
    checkOutput("rst_mem_req", {31'h0, mem_req}, 32'd0);
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'h0);
    checkOutput("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
    #10 reset_n = 1'b1;

    applyStimulus(32'h13, 3'b001, 0, 0, 0, 0, 1'b0, 32'hFFFF_FF80);
    applyStimulus(32'h13, 3'b101, 0, 0, 0, 0, 1'b0, 32'h0000_0080);
    applyStimulus(32'h10, 3'b001, 0, 0, 0, 0, 1'b0, 32'hFFFF_FFB3);
    applyStimulus(32'h11, 3'b101, 0, 0, 0, 0, 1'b0, 32'h0000_00A2);
    applyStimulus(32'h12, 3'b010, 0, 0, 0, 0, 1'b0, 32'hFFFF_8091);
    applyStimulus(32'h12, 3'b110, 0, 0, 0, 0, 1'b0, 32'h0000_8091);
    applyStimulus(32'h10, 3'b110, 0, 0, 0, 0, 1'b0, 32'h0000_A2B3);
    applyStimulus(32'h10, 3'b000, 0, 0, 0, 0, 1'b0, 32'h8091_A2B3);
    applyStimulus(32'h11, 3'b000, 0, 0, 0, 0, 1'b1, 32'h0);
    applyStimulus(32'h13, 3'b010, 0, 0, 0, 0, 1'b1, 32'h0);
    applyStimulus(32'h10, 3'b011, 0, 0, 0, 0, 1'b1, 32'h0);
    applyStimulus(32'h10, 3'b111, 0, 0, 0, 0, 1'b1, 32'h0);
    applyStimulus(32'h10, 3'b000, 3, 2, 0, 1, 1'b0, 32'h8091_A2B3);
    applyStimulus(32'h12, 3'b010, 0, 0, 5, 0, 1'b0, 32'hFFFF_8091);
    applyStimulus(32'h2010, 3'b000, 1, 1, 0, 0, 1'b0, 32'h8091_A2B3);
    applyStimulus(32'h1FFF, 3'b001, 0, 0, 0, 0, 1'b0, 32'h0000_007F);
    applyStimulus(32'h1FFE, 3'b010, 0, 0, 0, 0, 1'b0, 32'h0000_7F00);
    applyStimulus(32'h1FFC, 3'b010, 0, 0, 0, 0, 1'b0, 32'hFFFF_FF01);
    applyStimulus(32'h1FFC, 3'b110, 0, 0, 0, 0, 1'b0, 32'h0000_FF01);
    applyStimulus(32'h1FFD, 3'b001, 0, 0, 0, 0, 1'b0, 32'hFFFF_FFFF);

    // Reset while the read is outstanding; the late rvalid must not produce a response.
    @(posedge clock); #1;
    req_valid  = 1'b1;
    req_addr   = 32'h10;
    req_option = 3'b000;
    @(posedge clock); #1;
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(posedge clock); #1;
    mem_gnt = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_mem_req", {31'h0, mem_req}, 32'd0);
    checkOutput("midrst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    checkOutput("midrst_req_ready", {31'h0, req_ready}, 32'd0);
    checkOutput("midrst_rsp_data", rsp_data, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8091_A2B3;
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
    checkOutput("late_rv_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    checkOutput("late_rv_req_ready", {31'h0, req_ready}, 32'd1);
    @(posedge clock); #1;
    checkOutput("late_rv_rsp_valid2", {31'h0, rsp_valid}, 32'd0);
    checkOutput("late_rv_mem_req", {31'h0, mem_req}, 32'd0);

    applyStimulus(32'h11, 3'b101, 0, 0, 0, 0, 1'b0, 32'h0000_00A2);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
